// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined adder.
// Holds default WIDTH/STAGES, the per-stage segment width and a legality
// check used by the top at elaboration.
package adder_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;

  // Bits handled by each pipeline segment.
  function automatic int seg_width(input int width, input int stages);
    return width / stages;
  endfunction

  // Stage count must divide the width evenly and lie in 1..width.
  function automatic bit cfg_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_adder_fa_cell.sv
// One-bit combinational full adder used to build each segment's ripple chain.
// Ports: x, y operand bits; ci carry in; s sum bit; co carry out.
// Kept as its own cell so segment chains map onto dedicated carry logic.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder: sum = a + b + cin split into STAGES segments.
// Ports: clk/rst (async active-high); in_valid/in_ready + a, b, cin operands;
//   out_valid/out_ready + sum, cout, ovf result. Latency STAGES cycles.
// Optional ADDSUB_MODE_EN adds input sub: computes a + ~b + 1 when sub=1.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDSUB_MODE_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG = seg_width(WIDTH, STAGES);

  if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
    $error("pipelined_adder: WIDTH must be a multiple of STAGES, STAGES in 1..WIDTH");
  end

  // Whole pipe moves together; a stalled output freezes every stage.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage-0 operands. Subtract inverts B before it is skewed, so sub never
  // needs to travel down the pipe.
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
`ifdef ADDSUB_MODE_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  // Stage k adds bits [k*SEG +: SEG]. Operand registers carry only the bits
  // still to be added (upper skew); sum registers carry only the bits already
  // produced (lower skew), so sum emerges aligned at the last stage.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int OPW = WIDTH - k * SEG;
    localparam int LOW = (k + 1) * SEG;

    logic [OPW-1:0] x_w;
    logic [OPW-1:0] y_w;
    logic           ci_w;
    logic           v_w;
    logic [SEG:0]   ch;
    logic [SEG-1:0] seg_s;
    logic [LOW-1:0] s_nxt;

    logic           v_r;
    logic           c_r;
    logic [LOW-1:0] s_r;

    if (k == 0) begin : g_in
      assign x_w   = a;
      assign y_w   = b_eff;
      assign ci_w  = cin_eff;
      assign v_w   = in_valid;
      assign s_nxt = seg_s;
    end else begin : g_chain
      assign x_w   = g_stage[k-1].g_fwd.x_r;
      assign y_w   = g_stage[k-1].g_fwd.y_r;
      assign ci_w  = g_stage[k-1].c_r;
      assign v_w   = g_stage[k-1].v_r;
      assign s_nxt = {seg_s, g_stage[k-1].s_r};
    end

    assign ch[0] = ci_w;
    for (genvar i = 0; i < SEG; i++) begin : g_bit
      fa_cell u_fa (
        .x  (x_w[i]),
        .y  (y_w[i]),
        .ci (ch[i]),
        .s  (seg_s[i]),
        .co (ch[i+1])
      );
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_r <= 1'b0;
        c_r <= 1'b0;
        s_r <= '0;
      end else if (adv) begin
        v_r <= v_w;
        c_r <= ch[SEG];
        s_r <= s_nxt;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [OPW-SEG-1:0] x_r;
      logic [OPW-SEG-1:0] y_r;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          x_r <= '0;
          y_r <= '0;
        end else if (adv) begin
          x_r <= x_w[OPW-1:SEG];
          y_r <= y_w[OPW-1:SEG];
        end
      end
    end else begin : g_msb
      // Carry into bit WIDTH-1, kept beside cout for the overflow rule.
      logic cm_r;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cm_r <= 1'b0;
        end else if (adv) begin
          cm_r <= ch[SEG-1];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_r;
  assign sum       = g_stage[STAGES-1].s_r;
  assign cout      = g_stage[STAGES-1].c_r;
  assign ovf       = g_stage[STAGES-1].c_r ^ g_stage[STAGES-1].g_msb.cm_r;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (WIDTH=16, STAGES=4).
// Covers reset, carry ripple, overflow, streaming, back-pressure, mid-flight
// reset and, with ADDSUB_MODE_EN, subtraction.
module tb_pipelined_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
`ifdef ADDSUB_MODE_EN
  logic         sub;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef ADDSUB_MODE_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic cv, input logic vv);
    a        = av;
    b        = bv;
    cin      = cv;
    in_valid = vv;
  endtask

  // Sends one operand set and waits (bounded) for its result.
  task automatic xfer_wait(input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic cv, output logic [W-1:0] s,
                           output logic co, output logic ov, output int lat);
    drive(av, bv, cv, 1'b1);
    step();
    drive('0, '0, 1'b0, 1'b0);
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    s  = sum;
    co = cout;
    ov = ovf;
  endtask

  // Reference add with signed-overflow flag.
  function automatic logic [17:0] ref_add(input logic [W-1:0] av,
                                          input logic [W-1:0] bv,
                                          input logic cv);
    logic [16:0] r;
    logic        o;
    r = {1'b0, av} + {1'b0, bv} + {16'd0, cv};
    o = (av[15] == bv[15]) && (r[15] != av[15]);
    return {o, r};
  endfunction

  task automatic test_reset();
    rst       = 1'b1;
    out_ready = 1'b1;
    drive('0, '0, 1'b0, 1'b0);
    repeat (2) step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum: got %h expected 0000", sum); end
    checks++; if ({cout, ovf} !== 2'b00) begin errors++; $display("FAIL reset_cout_ovf: got %b expected 00", {cout, ovf}); end
    rst = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_carry_chain();
    logic [W-1:0] s;
    logic co, ov;
    int lat;
    xfer_wait(16'hFFFF, 16'h0001, 1'b0, s, co, ov, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL carry_latency: got %0d expected 4", lat); end
    checks++; if ({co, ov, s} !== {1'b1, 1'b0, 16'h0000}) begin errors++; $display("FAIL carry_ffff: got cout=%b ovf=%b sum=%h expected 1 0 0000", co, ov, s); end
    xfer_wait(16'h0000, 16'hFFFF, 1'b1, s, co, ov, lat);
    checks++; if ({co, ov, s} !== {1'b1, 1'b0, 16'h0000}) begin errors++; $display("FAIL carry_cin: got cout=%b ovf=%b sum=%h expected 1 0 0000", co, ov, s); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] s;
    logic co, ov;
    int lat;
    xfer_wait(16'h7FFF, 16'h0001, 1'b0, s, co, ov, lat);
    checks++; if ({co, ov, s} !== {1'b0, 1'b1, 16'h8000}) begin errors++; $display("FAIL ovf_pos: got cout=%b ovf=%b sum=%h expected 0 1 8000", co, ov, s); end
    xfer_wait(16'h8000, 16'h8000, 1'b0, s, co, ov, lat);
    checks++; if ({co, ov, s} !== {1'b1, 1'b1, 16'h0000}) begin errors++; $display("FAIL ovf_neg: got cout=%b ovf=%b sum=%h expected 1 1 0000", co, ov, s); end
  endtask

  task automatic test_back_to_back();
    logic [17:0] exp [8];
    logic [W-1:0] av;
    int first, last, got;
    for (int i = 0; i < 8; i++) begin
      av     = 16'(i * 16'h1111);
      exp[i] = ref_add(av, 16'h0F0F, 1'(i % 2));
    end
    first = -1; last = -1; got = 0;
    out_ready = 1'b1;
    drive(16'h0000, 16'h0F0F, 1'b0, 1'b1);
    for (int cyc = 1; cyc <= 14; cyc++) begin
      step();
      if (out_valid) begin
        if (first < 0) first = cyc;
        last = cyc;
        if (got < 8) begin
          checks++;
          if ({ovf, cout, sum} !== exp[got]) begin
            errors++;
            $display("FAIL b2b_result[%0d]: got ovf=%b cout=%b sum=%h expected ovf=%b cout=%b sum=%h",
                     got, ovf, cout, sum, exp[got][17], exp[got][16], exp[got][15:0]);
          end
        end
        got++;
      end
      if (cyc < 8) drive(16'(cyc * 16'h1111), 16'h0F0F, 1'(cyc % 2), 1'b1);
      else         drive('0, '0, 1'b0, 1'b0);
    end
    checks++; if (first !== 4) begin errors++; $display("FAIL b2b_first_cycle: got %0d expected 4", first); end
    checks++; if (got !== 8) begin errors++; $display("FAIL b2b_count: got %0d expected 8", got); end
    checks++; if (last - first !== 7) begin errors++; $display("FAIL b2b_contiguous: got span %0d expected 7", last - first); end
  endtask

  task automatic test_backpressure();
    localparam int N = 6;
    logic [17:0] exp [N];
    int sent, rcv;
    logic in_x, out_x;
    for (int i = 0; i < N; i++)
      exp[i] = ref_add(16'(16'h2000 * i + 16'h00FF), 16'h0101, 1'b1);
    sent = 0; rcv = 0;
    for (int cyc = 0; cyc < 40 && rcv < N; cyc++) begin
      out_ready = !(cyc >= 5 && cyc < 10);
      if (sent < N) drive(16'(16'h2000 * sent + 16'h00FF), 16'h0101, 1'b1, 1'b1);
      else          drive('0, '0, 1'b0, 1'b0);
      #1;
      if (cyc >= 5 && cyc < 10) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready@%0d: got %b expected 0", cyc, in_ready); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid@%0d: got %b expected 1", cyc, out_valid); end
        checks++; if (sum !== exp[rcv][15:0]) begin errors++; $display("FAIL bp_hold_sum@%0d: got %h expected %h", cyc, sum, exp[rcv][15:0]); end
      end
      in_x  = in_valid && in_ready;
      out_x = out_valid && out_ready;
      if (out_x) begin
        checks++;
        if ({ovf, cout, sum} !== exp[rcv]) begin
          errors++;
          $display("FAIL bp_result[%0d]: got %b%b_%h expected %b%b_%h", rcv, ovf, cout, sum,
                   exp[rcv][17], exp[rcv][16], exp[rcv][15:0]);
        end
        rcv++;
      end
      if (in_x) sent++;
      step();
    end
    out_ready = 1'b1;
    drive('0, '0, 1'b0, 1'b0);
    checks++; if (rcv !== N) begin errors++; $display("FAIL bp_count: got %0d expected %0d", rcv, N); end
  endtask

  task automatic test_reset_midflight();
    logic [W-1:0] s;
    logic co, ov;
    int lat, leaks;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(16'(16'h0100 * i + 1), 16'h0010, 1'b0, 1'b1);
      step();
    end
    drive('0, '0, 1'b0, 1'b0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %b expected 1", out_valid); end
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_async_valid: got %b expected 0", out_valid); end
    step();
    rst = 1'b0;
    leaks = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid) leaks++;
    end
    checks++; if (leaks !== 0) begin errors++; $display("FAIL midrst_stale_results: got %0d expected 0", leaks); end
    xfer_wait(16'h1234, 16'h4321, 1'b1, s, co, ov, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL midrst_latency: got %0d expected 4", lat); end
    checks++; if ({co, ov, s} !== {1'b0, 1'b0, 16'h5556}) begin errors++; $display("FAIL midrst_result: got cout=%b ovf=%b sum=%h expected 0 0 5556", co, ov, s); end
  endtask

`ifdef ADDSUB_MODE_EN
  task automatic test_subtract();
    logic [W-1:0] s;
    logic co, ov;
    int lat;
    sub = 1'b1;
    xfer_wait(16'h0005, 16'h0007, 1'b0, s, co, ov, lat);
    checks++; if ({co, ov, s} !== {1'b0, 1'b0, 16'hFFFE}) begin errors++; $display("FAIL sub_5_7: got cout=%b ovf=%b sum=%h expected 0 0 fffe", co, ov, s); end
    xfer_wait(16'h8000, 16'h0001, 1'b0, s, co, ov, lat);
    checks++; if ({co, ov, s} !== {1'b1, 1'b1, 16'h7FFF}) begin errors++; $display("FAIL sub_ovf: got cout=%b ovf=%b sum=%h expected 1 1 7fff", co, ov, s); end
    sub = 1'b0;
  endtask
`endif

  initial begin
`ifdef ADDSUB_MODE_EN
    sub = 1'b0;
`endif
    test_reset();
    test_carry_chain();
    test_overflow();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
`ifdef ADDSUB_MODE_EN
    test_subtract();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
